// File: rtl/mips32_dmem_resp.sv
// Word-addressed data-memory responder for the pipe_mips32 load/store port.
// Serves one request at a time with WAIT programmable wait states.
module mips32_dmem_resp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_we,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] WAIT_L = 4'(WAIT);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_we_q, rsp_we_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                mem_wr;

    // Bench-visible storage; never reset so preloaded contents survive rst_n.
    logic [31:0] Mem [2**ADDR_W];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        mem_wr      = 1'b0;
        req_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_L;
                    state_d = (WAIT == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                mem_wr      = we_q;
                rsp_rdata_d = we_q ? '0 : Mem[addr_q];
                rsp_we_d    = we_q;
                rsp_valid_d = 1'b1;
                if (we_q) begin
                    if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                end else begin
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst_n && mem_wr) Mem[addr_q] <= wdata_q;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mips32_dmem_resp.sv
// Self-checking bench for mips32_dmem_resp: transaction-level model plus
// directed latency, backpressure, reset and saturation scenarios.
module tb_mips32_dmem_resp;

    localparam int unsigned AW     = 10;
    localparam int          WAIT_A = 2;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst_n;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_we;
    logic [AW-1:0] a_req_addr;
    logic [31:0]   a_req_wdata, a_rsp_rdata;
    logic [15:0]   a_rd_count, a_wr_count;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_we;
    logic [AW-1:0] b_req_addr;
    logic [31:0]   b_req_wdata, b_rsp_rdata;
    logic [15:0]   b_rd_count, b_wr_count;

    mips32_dmem_resp #(.ADDR_W(AW), .WAIT(WAIT_A)) dut_a (
        .clk1(clk1), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_we(a_rsp_we), .rd_count(a_rd_count), .wr_count(a_wr_count)
    );

    mips32_dmem_resp #(.ADDR_W(AW), .WAIT(0)) dut_b (
        .clk1(clk1), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_we(b_rsp_we), .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: a request occupies the port for WAIT_A+1 edges after
    // acceptance, then its response is held until rsp_ready.
    bit          m_busy;
    int          m_age;
    logic        m_we;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wd;
    logic        e_valid, e_we;
    logic [31:0] e_rdata;
    logic [15:0] e_rd, e_wr;
    logic [31:0] m_mem [1024];

    always @(posedge clk1) begin
        if (!rst_n) begin
            m_busy = 0; m_age = 0; e_valid = 0; e_we = 0; e_rdata = 0; e_rd = 0; e_wr = 0;
        end else if (!m_busy) begin
            if (a_req_valid) begin
                m_busy = 1; m_age = 0;
                m_we = a_req_we; m_addr = a_req_addr; m_wd = a_req_wdata;
            end
        end else if (!e_valid) begin
            m_age++;
            if (m_age == WAIT_A + 1) begin
                if (m_we) begin
                    m_mem[m_addr] = m_wd;
                    e_rdata = 0;
                    if (e_wr != 16'hFFFF) e_wr++;
                end else begin
                    e_rdata = m_mem[m_addr];
                    if (e_rd != 16'hFFFF) e_rd++;
                end
                e_we = m_we;
                e_valid = 1;
            end
        end else if (a_rsp_ready) begin
            e_valid = 0; m_busy = 0;
        end
    end

    always @(negedge clk1) begin
        if (cmp_en) begin
            chk("req_ready", a_req_ready, {31'd0, !m_busy});
            chk("rsp_valid", a_rsp_valid, e_valid);
            chk("rsp_rdata", a_rsp_rdata, e_rdata);
            chk("rsp_we", a_rsp_we, e_we);
            chk("rd_count", a_rd_count, e_rd);
            chk("wr_count", a_wr_count, e_wr);
        end
    end

    task automatic step();
        @(posedge clk1); #2;
    endtask

    task automatic do_reset();
        a_req_valid = 0; b_req_valid = 0;
        rst_n = 0; step(); step(); rst_n = 1;
    endtask

    // Issue one request on dut_a; returns edges from accept to rsp_valid seen,
    // leaving the caller at the negedge where rsp_valid was first observed.
    task automatic issue_a(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                           output int lat);
        int  n;
        bit  acc, got;
        a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            @(negedge clk1); acc = a_req_ready;
            @(posedge clk1); n++;
        end
        #2 a_req_valid = 0;
        chk("accepted", {31'd0, acc}, 32'd1);
        lat = 0; got = 0;
        while (!got && lat < 60) begin
            @(posedge clk1); lat++;
            @(negedge clk1); got = a_rsp_valid;
        end
        chk("rsp_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int  lat, n;
        bit  acc, got, seen;
        rst_n = 0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        do_reset();
        cmp_en = 1;

        // Load with WAIT=2
        dut_a.Mem[120] = 32'd85; m_mem[120] = 32'd85;
        issue_a(1'b0, 10'd120, 32'd0, lat);
        chk("t1_latency", lat, 32'd3);
        chk("t1_rdata", a_rsp_rdata, 32'd85);
        chk("t1_we", {31'd0, a_rsp_we}, 32'd0);
        chk("t1_rd_count", {16'd0, a_rd_count}, 32'd1);
        @(posedge clk1); @(negedge clk1);
        chk("t1_one_cycle", {31'd0, a_rsp_valid}, 32'd0);
        #2;

        // Store then read back
        do_reset();
        issue_a(1'b1, 10'd121, 32'd130, lat);
        chk("t2_store_rdata", a_rsp_rdata, 32'd0);
        chk("t2_store_we", {31'd0, a_rsp_we}, 32'd1);
        step();
        issue_a(1'b0, 10'd121, 32'd0, lat);
        chk("t2_load_rdata", a_rsp_rdata, 32'd130);
        chk("t2_wr_count", {16'd0, a_wr_count}, 32'd1);
        chk("t2_rd_count", {16'd0, a_rd_count}, 32'd1);
        step();

        // Backpressure with a competing request offered
        a_rsp_ready = 0;
        issue_a(1'b0, 10'd120, 32'd0, lat);
        for (int i = 0; i < 5; i++) begin
            step();
            a_req_valid = 1; a_req_we = 1; a_req_addr = 10'd120; a_req_wdata = 32'd999;
            @(negedge clk1);
            chk("t3_hold_valid", {31'd0, a_rsp_valid}, 32'd1);
            chk("t3_hold_rdata", a_rsp_rdata, 32'd85);
            chk("t3_hold_ready", {31'd0, a_req_ready}, 32'd0);
        end
        step();
        a_req_valid = 0; a_rsp_ready = 1;
        repeat (6) step();
        chk("t3_mem_kept", dut_a.Mem[120], 32'd85);
        chk("t3_wr_count", {16'd0, a_wr_count}, 32'd1);

        // WAIT=0 instance
        dut_b.Mem[0] = 32'h28010078;
        b_req_valid = 1; b_req_we = 0; b_req_addr = '0;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            @(negedge clk1); acc = b_req_ready;
            @(posedge clk1); n++;
        end
        #2 b_req_valid = 0;
        chk("t4_accepted", {31'd0, acc}, 32'd1);
        lat = 0; got = 0;
        while (!got && lat < 60) begin
            @(posedge clk1); lat++;
            @(negedge clk1); got = b_rsp_valid;
        end
        chk("t4_latency", lat, 32'd1);
        chk("t4_rdata", b_rsp_rdata, 32'h28010078);
        chk("t4_rd_count", {16'd0, b_rd_count}, 32'd1);
        step();

        // Reset while a store is waiting
        do_reset();
        dut_a.Mem[5] = 32'h11111111; m_mem[5] = 32'h11111111;
        issue_a(1'b0, 10'd120, 32'd0, lat);
        step();
        a_req_valid = 1; a_req_we = 1; a_req_addr = 10'd5; a_req_wdata = 32'hDEADBEEF;
        @(negedge clk1); acc = a_req_ready;
        @(posedge clk1); #2;
        a_req_valid = 0; rst_n = 0;
        step();
        rst_n = 1;
        chk("t5_accepted", {31'd0, acc}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1); if (a_rsp_valid) seen = 1;
        end
        chk("t5_no_rsp", {31'd0, seen}, 32'd0);
        chk("t5_mem5", dut_a.Mem[5], 32'h11111111);
        chk("t5_req_ready", {31'd0, a_req_ready}, 32'd1);
        chk("t5_rd_count", {16'd0, a_rd_count}, 32'd0);
        chk("t5_wr_count", {16'd0, a_wr_count}, 32'd0);
        #2;

        // Store counter saturation from a preloaded value
        do_reset();
        dut_a.wr_count_q = 16'hFFFE; e_wr = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            issue_a(1'b1, 10'(200 + i), 32'(i + 7), lat);
            step();
        end
        @(negedge clk1);
        chk("t6_wr_sat", {16'd0, a_wr_count}, 32'h0000FFFF);
        chk("t6_mem202", dut_a.Mem[202], 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
